// File: rtl/timer_scheduler.sv
// Shared delay timer with round-robin arbitration among NREQ requesters.
// A requester's delay is latched at grant time. The owner gets a one-cycle done pulse on expiry.
//   state | meaning
//   IDLE  | no owner; arbitrate among pending requests from rr_ptr
//   COUNT | owner's job running; elapsed counts up to the latched delay
//   DONE  | one-cycle done pulse to the owner, then hand back to IDLE
module timer_scheduler #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  RST,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*WIDTH-1:0] delay,
   output logic [NREQ-1:0]       grant,
   output logic [NREQ-1:0]       done,
   output logic                  busy,
   output logic [WIDTH-1:0]      elapsed
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

   state_t            state, state_nxt;
   logic [PW-1:0]     rr_ptr, rr_ptr_nxt;
   logic [PW-1:0]     owner, owner_nxt, owner_inc;
   logic [WIDTH-1:0]  lat, lat_nxt;
   logic [WIDTH-1:0]  elapsed_nxt;
   logic [NREQ-1:0]   grant_nxt, done_nxt;
   logic              busy_nxt;
   logic              found;
   logic [PW-1:0]     sel;

   // First pending request at or above rr_ptr, wrapping modulo NREQ.
   always_comb begin
      found = 1'b0;
      sel   = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (!found && req[(int'(rr_ptr) + i) % NREQ]) begin
            found = 1'b1;
            sel   = PW'((int'(rr_ptr) + i) % NREQ);
         end
      end
   end

   assign owner_inc = (int'(owner) == NREQ - 1) ? '0 : owner + 1'b1;

   always_comb begin
      state_nxt   = state;
      rr_ptr_nxt  = rr_ptr;
      owner_nxt   = owner;
      lat_nxt     = lat;
      elapsed_nxt = elapsed;
      grant_nxt   = grant;
      done_nxt    = '0;
      busy_nxt    = busy;
      case (state)
         IDLE: begin
            grant_nxt   = '0;
            busy_nxt    = 1'b0;
            elapsed_nxt = '0;
            if (found) begin
               state_nxt = COUNT;
               owner_nxt = sel;
               lat_nxt   = delay[int'(sel)*WIDTH +: WIDTH];
               grant_nxt = NREQ'(1) << sel;
               busy_nxt  = 1'b1;
            end
         end
         COUNT: begin
            // A cancel wins over expiry in the same cycle: no done once req drops.
            if (!req[owner]) begin
               state_nxt   = IDLE;
               grant_nxt   = '0;
               busy_nxt    = 1'b0;
               elapsed_nxt = '0;
               rr_ptr_nxt  = owner_inc;
            end else if (elapsed == lat) begin
               state_nxt = DONE;
               done_nxt  = grant;
            end else begin
               elapsed_nxt = elapsed + 1'b1;
            end
         end
         DONE: begin
            state_nxt   = IDLE;
            grant_nxt   = '0;
            busy_nxt    = 1'b0;
            elapsed_nxt = '0;
            rr_ptr_nxt  = owner_inc;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (RST) begin
         state   <= IDLE;
         rr_ptr  <= '0;
         owner   <= '0;
         lat     <= '0;
         elapsed <= '0;
         grant   <= '0;
         done    <= '0;
         busy    <= 1'b0;
      end else begin
         state   <= state_nxt;
         rr_ptr  <= rr_ptr_nxt;
         owner   <= owner_nxt;
         lat     <= lat_nxt;
         elapsed <= elapsed_nxt;
         grant   <= grant_nxt;
         done    <= done_nxt;
         busy    <= busy_nxt;
      end
   end

endmodule

// File: tb/tb_timer_scheduler.sv
// Directed bench for timer_scheduler: expected done pulses (value and cycle) are queued
// as jobs are launched and matched by a negedge monitor; grant/busy/elapsed checked inline.
module tb_timer_scheduler;

   localparam int NREQ  = 4;
   localparam int WIDTH = 8;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [NREQ-1:0]       req;
   logic [NREQ*WIDTH-1:0] delay_bus;
   logic [NREQ-1:0]       grant;
   logic [NREQ-1:0]       done;
   logic                  busy;
   logic [WIDTH-1:0]      elapsed;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   typedef struct {
      logic [NREQ-1:0] val;
      int              cyc;
   } exp_t;
   exp_t q[$];
   exp_t mon_e;

   timer_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
      .clk     (clk),
      .RST     (rst),
      .req     (req),
      .delay   (delay_bus),
      .grant   (grant),
      .done    (done),
      .busy    (busy),
      .elapsed (elapsed)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
      end
   endtask

   task automatic push_done(input logic [NREQ-1:0] v, input int c);
      q.push_back('{val: v, cyc: c});
   endtask

   // Scoreboard monitor: every done pulse must match the head of the queue, on time.
   always @(negedge clk) begin
      chk("grant_onehot0", {31'd0, $onehot0(grant)}, 32'd1);
      if (done !== '0) begin
         if (q.size() == 0) begin
            chk("done_unexpected", done, 32'd0);
         end else begin
            mon_e = q.pop_front();
            chk("done_val", done, mon_e.val);
            chk("done_cyc", cyc, mon_e.cyc);
         end
      end else if (q.size() != 0 && cyc > q[0].cyc) begin
         mon_e = q.pop_front();
         chk("done_missing", done, mon_e.val);
      end
   end

   initial begin
      int c0;
      logic [NREQ-1:0] one;
      one       = 4'b0001;
      rst       = 1'b1;
      req       = '0;
      delay_bus = '0;
      repeat (2) @(negedge clk);
      chk("rst_grant", grant, 0);
      chk("rst_done", done, 0);
      chk("rst_busy", busy, 0);
      chk("rst_elapsed", elapsed, 0);
      rst = 1'b0;

      // Single job, delay 3; delay change after grant must be ignored.
      delay_bus[0 +: 8] = 8'd3;
      req = 4'b0001;
      c0  = cyc;
      push_done(4'b0001, c0 + 5);
      @(negedge clk);
      chk("t1_grant", grant, 4'b0001);
      chk("t1_busy", busy, 1);
      delay_bus[0 +: 8] = 8'd50;
      for (int i = 0; i < 4; i++) begin
         if (i > 0) @(negedge clk);
         chk("t1_elapsed", elapsed, i);
      end
      @(negedge clk);
      chk("t1_grant_done", grant, 4'b0001);
      req = '0;
      @(negedge clk);
      chk("t1_grant_idle", grant, 0);
      chk("t1_busy_idle", busy, 0);
      chk("t1_elapsed_idle", elapsed, 0);

      // Zero delay: busy exactly two cycles.
      delay_bus[16 +: 8] = 8'd0;
      req = 4'b0100;
      c0  = cyc;
      push_done(4'b0100, c0 + 2);
      @(negedge clk);
      chk("t2_grant", grant, 4'b0100);
      chk("t2_busy1", busy, 1);
      @(negedge clk);
      chk("t2_busy2", busy, 1);
      req = '0;
      @(negedge clk);
      chk("t2_busy_off", busy, 0);

      // Round-robin over all four, delay 1, starting from a fresh reset.
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < NREQ; i++) delay_bus[i*WIDTH +: WIDTH] = 8'd1;
      req = 4'b1111;
      c0  = cyc;
      for (int j = 0; j < 5; j++) push_done(one << (j % 4), c0 + 3 + 4*j);
      for (int j = 0; j < 5; j++) begin
         repeat ((j == 0) ? 1 : 4) @(negedge clk);
         chk("t3_grant", grant, one << (j % 4));
      end
      repeat (2) @(negedge clk);
      req = '0;
      @(negedge clk);
      chk("t3_grant_end", grant, 0);
      @(negedge clk);
      chk("t3_no_regrant", grant, 0);

      // Fairness: 0 and 2 held, delay 2.
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      delay_bus[0 +: 8]  = 8'd2;
      delay_bus[16 +: 8] = 8'd2;
      req = 4'b0101;
      c0  = cyc;
      for (int j = 0; j < 4; j++) push_done((j % 2 == 0) ? 4'b0001 : 4'b0100, c0 + 4 + 5*j);
      for (int j = 0; j < 4; j++) begin
         repeat ((j == 0) ? 1 : 5) @(negedge clk);
         chk("t4_grant", grant, (j % 2 == 0) ? 4'b0001 : 4'b0100);
      end
      repeat (3) @(negedge clk);
      req = '0;
      @(negedge clk);
      chk("t4_grant_end", grant, 0);

      // Cancel: req1 dropped at elapsed 4, pending req3 granted after one idle cycle.
      delay_bus[8 +: 8] = 8'd10;
      req = 4'b0010;
      c0  = cyc;
      @(negedge clk);
      chk("t5_grant", grant, 4'b0010);
      delay_bus[24 +: 8] = 8'd0;
      req = 4'b1010;
      repeat (4) @(negedge clk);
      chk("t5_elapsed4", elapsed, 4);
      req = 4'b1000;
      push_done(4'b1000, c0 + 8);
      @(negedge clk);
      chk("t5_cancel_grant", grant, 0);
      chk("t5_cancel_busy", busy, 0);
      chk("t5_cancel_elapsed", elapsed, 0);
      @(negedge clk);
      chk("t5_pending_grant", grant, 4'b1000);
      @(negedge clk);
      req = '0;
      @(negedge clk);

      // Move rr_ptr off zero, then reset mid-job and expect requester 0 first.
      delay_bus[8 +: 8] = 8'd0;
      req = 4'b0010;
      c0  = cyc;
      push_done(4'b0010, c0 + 2);
      @(negedge clk);
      chk("t6_pre_grant", grant, 4'b0010);
      @(negedge clk);
      req = '0;
      @(negedge clk);
      delay_bus[24 +: 8] = 8'd20;
      delay_bus[0 +: 8]  = 8'd1;
      req = 4'b1000;
      c0  = cyc;
      @(negedge clk);
      chk("t6_grant3", grant, 4'b1000);
      req = 4'b1001;
      repeat (5) @(negedge clk);
      chk("t6_elapsed5", elapsed, 5);
      rst = 1'b1;
      @(negedge clk);
      chk("t6_rst_grant", grant, 0);
      chk("t6_rst_done", done, 0);
      chk("t6_rst_busy", busy, 0);
      chk("t6_rst_elapsed", elapsed, 0);
      rst = 1'b0;
      push_done(4'b0001, c0 + 10);
      @(negedge clk);
      chk("t6_grant_after_rst", grant, 4'b0001);
      repeat (2) @(negedge clk);
      req = '0;
      @(negedge clk);

      // Maximum delay: counting stops at equality, no wrap.
      delay_bus[16 +: 8] = 8'd255;
      req = 4'b0100;
      c0  = cyc;
      push_done(4'b0100, c0 + 257);
      @(negedge clk);
      chk("t7_elapsed0", elapsed, 0);
      repeat (255) @(negedge clk);
      chk("t7_elapsed_max", elapsed, 255);
      chk("t7_busy", busy, 1);
      @(negedge clk);
      chk("t7_busy_done", busy, 1);
      req = '0;
      @(negedge clk);
      chk("t7_busy_off", busy, 0);
      chk("t7_elapsed_off", elapsed, 0);

      repeat (3) @(negedge clk);
      chk("sb_empty", q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/timer_scheduler.md
TIMER_SCHEDULER -- requirements
Module: timer_scheduler

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing the timer (2..8).
REQ-002 Parameter WIDTH, default 32, width of delay values and the elapsed counter.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 RST  input  1  reset, synchronous, active-high.
REQ-005 req  input  NREQ  level request per requester; held high until done or until the requester cancels.
REQ-006 delay  input  NREQ*WIDTH  per-requester delay; slice i is bits [i*WIDTH +: WIDTH].
REQ-007 grant  output  NREQ  one-hot owner of the timer; all-zero when idle.
REQ-008 done  output  NREQ  one-hot, one-cycle pulse when the owner's delay has expired.
REQ-009 busy  output  1  high while the timer is owned (COUNT or DONE).
REQ-010 elapsed  output  WIDTH  current count of the active job; 0 when idle.

Function
REQ-011 FSM states SHALL be IDLE, COUNT and DONE, and all outputs SHALL be registered.
REQ-012 IDLE: if any req bit is high, the block SHALL select the first set bit scanning upward from rr_ptr with wrap-around (modulo NREQ), latch that requester's delay, set grant to its bit, clear elapsed and enter COUNT.
REQ-013 IDLE with req all-zero SHALL remain in IDLE with grant, done and busy at 0.
REQ-014 COUNT: if elapsed equals the latched delay, the block SHALL enter DONE; otherwise elapsed SHALL increment by 1.
REQ-015 COUNT SHALL last exactly latched_delay+1 cycles, including delay=0 (one cycle) and delay=2^WIDTH-1 (no overflow, since counting stops at equality).
REQ-016 DONE SHALL last one cycle, drive done equal to grant and hold grant and busy, then enter IDLE with rr_ptr set to (owner+1) mod NREQ.
REQ-017 Latency: a req sampled in IDLE at edge k SHALL give grant from cycle k+1 and a done pulse in cycle k+2+delay.
REQ-018 Changes on delay after grant SHALL be ignored, because the value is latched at selection.
REQ-019 Cancel: if the owner's req bit is low at an edge in COUNT, the block SHALL enter IDLE, clear grant, busy and elapsed, issue no done, and set rr_ptr to (owner+1) mod NREQ.
REQ-020 Requests from non-owners during COUNT or DONE SHALL be held pending, not lost, and SHALL be arbitrated at the next IDLE.
REQ-021 A requester still high in the IDLE cycle after its done SHALL be treated as a new request, subject to the round-robin order.
REQ-022 At most one grant bit and at most one done bit SHALL be high in any cycle.
REQ-023 Each IDLE→COUNT hand-over SHALL consume one IDLE cycle, so the minimum job-to-job gap is one cycle.

Reset
REQ-024 When RST is high at an edge, the block SHALL enter IDLE and set grant=0, done=0, busy=0, elapsed=0, rr_ptr=0 and latched delay=0.
REQ-025 RST SHALL take priority over every transition, including mid-COUNT and in DONE, and the in-flight job SHALL be dropped with no done pulse.
REQ-026 The first arbitration after reset SHALL favour requester 0.

Verification
REQ-027 Single job: req=0001, delay0=3, held high → grant=0001 from cycle k+1, elapsed counts 0,1,2,3, done=0001 for exactly one cycle at k+5, then grant=0.
REQ-028 Zero delay: req=0100, delay2=0 → one COUNT cycle, done=0100 at k+2, busy high for exactly 2 cycles.
REQ-029 Round-robin: req=1111 all held and re-raised, all delays=1 → grant sequence 0001,0010,0100,1000,0001; each requester receives done once per round.
REQ-030 Fairness: req0 and req2 held continuously, delays=2 → grants alternate 0001,0100,0001,... and neither requester gets two consecutive grants.
REQ-031 Cancel: req1 granted with delay1=10, req1 dropped at elapsed=4 → grant=0 the next cycle, no done pulse, and pending req3 is granted after one IDLE cycle.
REQ-032 Reset mid-job: RST pulsed at elapsed=5 of a delay=20 job → all outputs 0 the next cycle, no done pulse, and with req=1001 still high the next grant is 0001.
